wave_tbl_writer: RTL and testbench
==================================

Name: wave_tbl_writer

Overview:
- Loads a DDS waveform table (for example a square, sine or triangle wave of 1024 x 8) from a byte stream into the write port of a simple dual-port RAM.
- The RAM's read port feeds the DDS phase-to-amplitude lookup, so the block is the writer for the waveform table.
- Accepts a start command, then exactly 2^ADDR_WIDTH data bytes, then one checksum byte.
- Reports done, checksum error and timeout, and asserts tbl_valid so the DDS may switch to the new table.

Parameters:
- ADDR_WIDTH, 10: table address width; table depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 8: sample width; the stream byte width equals DATA_WIDTH.
- TIMEOUT_CYC, 1000000: maximum idle cycles between accepted bytes while loading; minimum value 2.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle pulse that begins a load; ignored unless the block is in IDLE or DONE.
- abort, input, 1: abandons a load in progress; returns to IDLE.
- s_data, input, DATA_WIDTH: stream data byte.
- s_valid, input, 1: stream data valid.
- s_ready, output, 1: block accepts s_data this cycle.
- wr_en, output, 1: RAM write enable.
- wr_addr, output, ADDR_WIDTH: RAM write address.
- wr_data, output, DATA_WIDTH: RAM write data.
- busy, output, 1: high in LOAD and CHECK.
- done, output, 1: one-cycle pulse at the end of every load that ends in CHECK (checksum pass or fail).
- err_cksum, output, 1: sticky checksum mismatch; cleared by start.
- err_timeout, output, 1: sticky timeout; cleared by start.
- tbl_valid, output, 1: the table holds a complete, checksum-verified image.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal address counter, checksum accumulator and timeout counter all 0.
- States are IDLE, LOAD, CHECK and DONE.
- IDLE or DONE, on start:
  - go to LOAD;
  - clear the address counter, checksum accumulator, err_cksum, err_timeout and tbl_valid;
  - reload the timeout counter.
- LOAD:
  - s_ready = 1; a handshake occurs when s_valid && s_ready.
  - On a handshake, the next cycle has wr_en = 1, wr_addr = address counter, wr_data = s_data. Write latency is 1 cycle; outputs are registered.
  - On the same handshake, the address counter increments, the checksum accumulator adds s_data modulo 2^DATA_WIDTH, and the timeout counter reloads.
  - Continuous back-to-back handshakes are sustained at 1 byte per cycle.
  - When the handshake at address 2^ADDR_WIDTH-1 completes, go to CHECK. The address counter must not wrap into a second write at address 0.
- CHECK:
  - s_ready = 1 and wr_en = 0; the next accepted byte is the checksum.
  - The checksum is compared to the accumulator, which holds the sum of all data bytes truncated to DATA_WIDTH.
  - On a match: tbl_valid = 1 and err_cksum = 0. On a mismatch: tbl_valid = 0 and err_cksum = 1.
  - done pulses the cycle after the checksum is accepted; the state becomes DONE in that same cycle.
- DONE: s_ready = 0; holds the flags until the next start.
- Timeout (LOAD or CHECK):
  - The timeout counter decrements on every cycle without a handshake.
  - On reaching 0: err_timeout = 1, tbl_valid = 0, go to IDLE, no done pulse.
  - Any RAM writes already made remain in place; tbl_valid stays 0.
- abort:
  - In LOAD or CHECK, go to IDLE on the next cycle; s_ready drops that cycle and the byte is not consumed.
  - tbl_valid = 0; error flags are unchanged; no done pulse.
  - abort takes priority over a simultaneous handshake and over a timeout.
  - Ignored in IDLE and DONE.
- start during LOAD or CHECK: ignored.
- start and abort together in IDLE or DONE: start wins.
- Asynchronous reset mid-load: immediate return to the reset values. The RAM contents are undefined to the consumer; tbl_valid = 0.
- While in LOAD, s_ready does not depend combinationally on s_valid.

Decomposition:
- Shared package for the DDS table path:
  - state enum: IDLE, LOAD, CHECK, DONE;
  - table depth constant (1 << ADDR_WIDTH);
  - default sample width;
  - timeout default.
- Natural sub-module: wave_tbl_timeout, a loadable down-counter with a reload and expire flag, reusable by other stream-fed loaders.
- Everything else stays in a single FSM module.

Test Plan:
- Full load: start, then 1024 bytes with byte i = i[7:0] back-to-back, then checksum 0x00 (sum of 4 x 0..255 = 4 x 32640 = 130560, which is 0x00 modulo 256).
  - Response: 1024 writes at addresses 0..1023 with data i[7:0], each 1 cycle after its handshake.
  - Response: done pulses once; tbl_valid = 1; err_cksum = 0.
- Square-wave image: 512 x 0xFF then 512 x 0x00, with s_valid toggling every other cycle, then checksum 0x00 (512 x 255 modulo 256 = 0).
  - Response: tbl_valid = 1; no writes on cycles without a handshake.
- Bad checksum: the same stream as the full load with checksum 0x01.
  - Response: done pulses; err_cksum = 1; tbl_valid = 0; state DONE.
  - A new start clears err_cksum.
- Timeout: TIMEOUT_CYC = 16; send 100 bytes, then hold s_valid = 0.
  - Response: 16 cycles after the last handshake, err_timeout = 1 and busy = 0; no done pulse; exactly 100 writes.
- Abort: abort after byte 300, asserted on the same cycle as a valid byte.
  - Response: that byte is not written; IDLE next cycle; tbl_valid = 0.
  - A following start/load from address 0 succeeds.
- Reset mid-load: assert rst_n low at byte 500.
  - Response: all outputs 0 asynchronously.
  - After release, start is accepted and a fresh load completes with tbl_valid = 1.

Source files
------------

// File: rtl/wave_tbl_writer_pkg.sv
// Shared types and defaults for the DDS waveform-table load path.
package wave_tbl_writer_pkg;

   // Loader states
   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StCheck,
      StDone
   } wt_state_e;

   localparam int unsigned DefAddrWidth  = 10;
   localparam int unsigned DefDataWidth  = 8;
   localparam int unsigned DefTimeoutCyc = 1000000;
   localparam int unsigned TblDepth      = 1 << DefAddrWidth;

endpackage

// File: rtl/wave_tbl_writer_if.sv
// Byte-stream input and RAM write port of the waveform-table loader.
interface wave_tbl_writer_if #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_ready;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;

   // Environment side: drives the stream, observes the RAM writes
   modport master (
      output s_data, s_valid,
      input  s_ready, wr_en, wr_addr, wr_data
   );

   // Loader side
   modport slave (
      input  s_data, s_valid,
      output s_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/wave_tbl_timeout.sv
// Loadable idle-cycle down-counter; expire flags the last remaining cycle.
module wave_tbl_timeout #(
   parameter int unsigned LOAD_VAL = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic reload,
   input  logic dec,
   output logic expire
);
   localparam int unsigned Width = $clog2(LOAD_VAL + 1);

   logic [Width-1:0] count_q, count_d;

   // Reload wins over decrement; counter parks at zero
   always_comb begin
      count_d = count_q;
      if (reload) begin
         count_d = Width'(LOAD_VAL);
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - Width'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // A decrement from 1 reaches zero at the coming edge
   assign expire = (count_q == Width'(1));

endmodule

// File: rtl/wave_tbl_writer.sv
// Loads a DDS waveform table from a byte stream: 2^ADDR_WIDTH samples, then one checksum byte.
module wave_tbl_writer
   import wave_tbl_writer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
   parameter int unsigned DATA_WIDTH  = DefDataWidth,
   parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   wave_tbl_writer_if.slave   tbl,
   output logic               busy,
   output logic               done,
   output logic               err_cksum,
   output logic               err_timeout,
   output logic               tbl_valid
);

   wt_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] cksum_q, cksum_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  done_q, done_d;
   logic                  err_cksum_q, err_cksum_d;
   logic                  err_timeout_q, err_timeout_d;
   logic                  tbl_valid_q, tbl_valid_d;

   logic in_xfer;
   logic rdy;
   logic hs;
   logic start_ok;
   logic tmo_reload;
   logic tmo_dec;
   logic tmo_expire;

   // Handshake decode kept outside the FSM so the timer never loops back through it
   assign in_xfer    = (state_q == StLoad) || (state_q == StCheck);
   assign rdy        = in_xfer && !abort;
   assign hs         = rdy && tbl.s_valid;
   assign start_ok   = ((state_q == StIdle) || (state_q == StDone)) && start;
   assign tmo_reload = start_ok || hs;
   assign tmo_dec    = in_xfer && !hs && !abort;

   wave_tbl_timeout #(
      .LOAD_VAL (TIMEOUT_CYC)
   ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .reload (tmo_reload),
      .dec    (tmo_dec),
      .expire (tmo_expire)
   );

   // Next-state and registered-output logic; abort beats handshake beats timeout
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      cksum_d       = cksum_q;
      wr_en_d       = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      done_d        = 1'b0;
      err_cksum_d   = err_cksum_q;
      err_timeout_d = err_timeout_q;
      tbl_valid_d   = tbl_valid_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start_ok) begin
               state_d       = StLoad;
               addr_d        = '0;
               cksum_d       = '0;
               err_cksum_d   = 1'b0;
               err_timeout_d = 1'b0;
               tbl_valid_d   = 1'b0;
            end
         end
         StLoad: begin
            if (abort) begin
               state_d     = StIdle;
               tbl_valid_d = 1'b0;
            end else if (hs) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = tbl.s_data;
               addr_d    = addr_q + 1'b1;
               cksum_d   = cksum_q + tbl.s_data;
               // Last sample moves on before the counter wraps into a second write
               if (addr_q == '1) begin
                  state_d = StCheck;
               end
            end else if (tmo_expire) begin
               state_d       = StIdle;
               err_timeout_d = 1'b1;
               tbl_valid_d   = 1'b0;
            end
         end
         StCheck: begin
            if (abort) begin
               state_d     = StIdle;
               tbl_valid_d = 1'b0;
            end else if (hs) begin
               state_d     = StDone;
               done_d      = 1'b1;
               tbl_valid_d = (tbl.s_data == cksum_q);
               err_cksum_d = (tbl.s_data != cksum_q);
            end else if (tmo_expire) begin
               state_d       = StIdle;
               err_timeout_d = 1'b1;
               tbl_valid_d   = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         addr_q        <= '0;
         cksum_q       <= '0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         done_q        <= 1'b0;
         err_cksum_q   <= 1'b0;
         err_timeout_q <= 1'b0;
         tbl_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         cksum_q       <= cksum_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         done_q        <= done_d;
         err_cksum_q   <= err_cksum_d;
         err_timeout_q <= err_timeout_d;
         tbl_valid_q   <= tbl_valid_d;
      end
   end

   assign tbl.s_ready = rdy;
   assign tbl.wr_en   = wr_en_q;
   assign tbl.wr_addr = wr_addr_q;
   assign tbl.wr_data = wr_data_q;
   assign busy        = in_xfer;
   assign done        = done_q;
   assign err_cksum   = err_cksum_q;
   assign err_timeout = err_timeout_q;
   assign tbl_valid   = tbl_valid_q;

endmodule

// File: tb/tb_wave_tbl_writer.sv
// Directed bench for wave_tbl_writer: full loads, square image, bad checksum, timeout, abort, reset.
module tb_wave_tbl_writer;
   localparam int unsigned AW  = 10;
   localparam int unsigned DW  = 8;
   localparam int unsigned TMO = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic busy, done, err_cksum, err_timeout, tbl_valid;

   int n_chk       = 0;
   int n_fail      = 0;
   int done_cnt    = 0;
   int load_writes = 0;
   int done_before;

   wave_tbl_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   wave_tbl_writer #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .tbl         (bus),
      .busy        (busy),
      .done        (done),
      .err_cksum   (err_cksum),
      .err_timeout (err_timeout),
      .tbl_valid   (tbl_valid)
   );

   always #5 clk = ~clk;

   // done is high for one full cycle, so each pulse is seen at exactly one falling edge
   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at the falling edge, check the registered write just after the rising edge
   task automatic step(input logic v, input logic [7:0] d, input logic ab,
                       input logic exp_wr, input logic [AW-1:0] exp_addr);
      @(negedge clk);
      start       = 1'b0;
      abort       = ab;
      bus.s_valid = v;
      bus.s_data  = d;
      @(posedge clk);
      #1;
      chk("wr_en", bus.wr_en, exp_wr);
      if (exp_wr) begin
         chk("wr_addr", bus.wr_addr, exp_addr);
         chk("wr_data", bus.wr_data, d);
      end
      if (bus.wr_en === 1'b1) load_writes++;
   endtask

   task automatic do_start();
      @(negedge clk);
      start       = 1'b1;
      abort       = 1'b0;
      bus.s_valid = 1'b0;
      @(posedge clk);
      #1;
      load_writes = 0;
      chk("start_busy", busy, 1'b1);
      chk("start_err_cksum", err_cksum, 1'b0);
      chk("start_err_timeout", err_timeout, 1'b0);
      chk("start_tbl_valid", tbl_valid, 1'b0);
   endtask

   // mode 0: ramp i[7:0] back-to-back; mode 1: square with an idle cycle before each byte
   task automatic send_bytes(input int mode, input int n);
      logic [AW-1:0] a;
      logic [7:0]    d;
      for (int i = 0; i < n; i++) begin
         a = AW'(i);
         if (mode == 0) begin
            d = a[7:0];
         end else begin
            d = (i < 512) ? 8'hFF : 8'h00;
            step(1'b0, 8'h5A, 1'b0, 1'b0, '0);
         end
         step(1'b1, d, 1'b0, 1'b1, a);
      end
   endtask

   task automatic send_cksum(input logic [7:0] ck, input logic exp_ok);
      step(1'b1, ck, 1'b0, 1'b0, '0);
      chk("done_pulse", done, 1'b1);
      chk("tbl_valid", tbl_valid, exp_ok);
      chk("err_cksum", err_cksum, !exp_ok);
      chk("done_busy", busy, 1'b0);
      chk("done_s_ready", bus.s_ready, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, '0);
      chk("done_single", done, 1'b0);
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;

      // Reset state
      @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_s_ready", bus.s_ready, 1'b0);
      chk("rst_wr_en", bus.wr_en, 1'b0);
      chk("rst_tbl_valid", tbl_valid, 1'b0);
      chk("rst_done", done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Full ramp load, checksum 0x00
      do_start();
      send_bytes(0, 1024);
      chk("full_writes", load_writes, 1024);
      send_cksum(8'h00, 1'b1);

      // Square image with gaps
      do_start();
      send_bytes(1, 1024);
      chk("sq_writes", load_writes, 1024);
      send_cksum(8'h00, 1'b1);

      // Bad checksum; the next start clears err_cksum
      do_start();
      send_bytes(0, 1024);
      send_cksum(8'h01, 1'b0);

      // Timeout: 100 bytes, then silence
      do_start();
      send_bytes(0, 100);
      done_before = done_cnt;
      for (int k = 1; k < int'(TMO); k++) begin
         step(1'b0, 8'h00, 1'b0, 1'b0, '0);
         chk("tmo_busy_pre", busy, 1'b1);
         chk("tmo_err_pre", err_timeout, 1'b0);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, '0);
      chk("tmo_err", err_timeout, 1'b1);
      chk("tmo_busy", busy, 1'b0);
      chk("tmo_tbl_valid", tbl_valid, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, '0);
      chk("tmo_no_done", done_cnt, done_before);
      chk("tmo_writes", load_writes, 100);

      // Abort on the same cycle as a valid byte
      do_start();
      send_bytes(0, 300);
      @(negedge clk);
      abort       = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hAA;
      #1;
      chk("abort_s_ready", bus.s_ready, 1'b0);
      @(posedge clk);
      #1;
      chk("abort_wr_en", bus.wr_en, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_tbl_valid", tbl_valid, 1'b0);
      chk("abort_err_timeout", err_timeout, 1'b0);
      chk("abort_done", done, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, '0);
      do_start();
      send_bytes(0, 1024);
      send_cksum(8'h00, 1'b1);

      // Asynchronous reset mid-load
      do_start();
      send_bytes(0, 500);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_wr_en", bus.wr_en, 1'b0);
      chk("arst_wr_addr", bus.wr_addr, 0);
      chk("arst_wr_data", bus.wr_data, 0);
      chk("arst_s_ready", bus.s_ready, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_tbl_valid", tbl_valid, 1'b0);
      chk("arst_done", done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      do_start();
      send_bytes(0, 1024);
      send_cksum(8'h00, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
